// File: rtl/mod_m_updown_counter_if.sv
// Bundles the control, data and status signals of one mod-M up/down
// counter so a counter can be handed around as a single port.
//
// Signals (direction as seen by the counter, i.e. the slave modport):
//   modM_i   in   N   runtime modulus M, count range 0..M-1
//   en_i     in   1   count enable
//   up_i     in   1   1 counts up, 0 counts down
//   clr_i    in   1   synchronous clear
//   load_i   in   1   synchronous parallel load
//   d_i      in   N   load value
//   q_o      out  N   current count (registered)
//   tc_o     out  1   terminal count / carry-out (combinational)
//   wraps_o  out  W   saturating count of wrap events (registered)
//
// The master modport is for whoever drives the counter: a controller,
// an upstream stage or a testbench.
interface mod_m_updown_counter_if #(
    parameter int N = 8,
    parameter int W = 4
);
    logic [N-1:0] modM_i;
    logic         en_i;
    logic         up_i;
    logic         clr_i;
    logic         load_i;
    logic [N-1:0] d_i;
    logic [N-1:0] q_o;
    logic         tc_o;
    logic [W-1:0] wraps_o;

    modport master (
        output modM_i, en_i, up_i, clr_i, load_i, d_i,
        input  q_o, tc_o, wraps_o
    );

    modport slave (
        input  modM_i, en_i, up_i, clr_i, load_i, d_i,
        output q_o, tc_o, wraps_o
    );
endinterface

// File: rtl/mod_m_updown_counter.sv
// Runtime-programmable mod-M up/down counter. It supports parallel load,
// synchronous clear, count enable, optional saturation (SAT=1) in place of
// wrapping, and a combinational cascade carry (tc). When counters are
// chained, the tc of one instance drives the en of the next.
//
// Parameters:
//   N    width of the count, modulus and load value
//   W    width of the saturating wrap-event counter
//   SAT  0 wraps at the range boundaries, 1 parks at them
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears q and wraps immediately
//   bus    slave side of mod_m_updown_counter_if (modulus, enable,
//          direction, clear, load, load value, count, tc, wraps)
module mod_m_updown_counter #(
    parameter int N   = 8,
    parameter int W   = 4,
    parameter int SAT = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    mod_m_updown_counter_if.slave       bus
);

    localparam bit SatMode = (SAT != 0);

    logic [N-1:0] countQ;
    logic [N-1:0] countD;
    logic [W-1:0] wrapsQ;
    logic [W-1:0] wrapsD;

    logic [N-1:0] lastVal;
    logic [N-1:0] loadVal;
    logic         degenerate;
    logic         inRange;
    logic         atTop;
    logic         atBottom;
    logic         tcInt;
    logic         wrapEvent;

    // M-1 is only meaningful when M>=2; on the degenerate path it is never
    // used, so the underflow of 0-1 or 1-1 is harmless.
    assign lastVal    = bus.modM_i - N'(1);
    assign degenerate = (bus.modM_i < N'(2));
    assign inRange    = (countQ < bus.modM_i);
    assign atTop      = (countQ == lastVal);
    assign atBottom   = (countQ == '0);

    // A load value outside the range is clamped to the top of the range.
    assign loadVal = (bus.d_i < bus.modM_i) ? bus.d_i : lastVal;

    // Carry-out. With M<2 every enabled edge counts as a full cycle, so tc
    // simply follows en. Otherwise tc is raised only when the next enabled
    // edge would cross a boundary and nothing of higher priority (clear,
    // load, out-of-range fix) will take that edge instead. Reading only
    // registered q and the inputs keeps tc free of loops back into q.
    always_comb begin
        tcInt = 1'b0;
        if (degenerate) begin
            tcInt = bus.en_i;
        end else if (bus.en_i && !bus.clr_i && !bus.load_i && inRange) begin
            tcInt = bus.up_i ? atTop : atBottom;
        end
    end

    // Next count. Priority is clear, then load, then pulling a stale count
    // back into range (after mod_m shrinks), then counting. Boundary cases
    // are handled before the +1/-1 so neither can overflow.
    always_comb begin
        countD = countQ;
        if (degenerate) begin
            countD = '0;
        end else if (bus.clr_i) begin
            countD = '0;
        end else if (bus.load_i) begin
            countD = loadVal;
        end else if (!inRange) begin
            countD = '0;
        end else if (bus.en_i) begin
            if (bus.up_i) begin
                if (atTop) begin
                    countD = SatMode ? countQ : '0;
                end else begin
                    countD = countQ + N'(1);
                end
            end else begin
                if (atBottom) begin
                    countD = SatMode ? countQ : lastVal;
                end else begin
                    countD = countQ - N'(1);
                end
            end
        end
    end

    // A wrap happens exactly on the edges where tc is high, and never in
    // saturating mode. The event counter sticks at all-ones.
    assign wrapEvent = tcInt && !SatMode;

    always_comb begin
        wrapsD = wrapsQ;
        if (wrapEvent && (wrapsQ != '1)) begin
            wrapsD = wrapsQ + W'(1);
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countQ <= '0;
            wrapsQ <= '0;
        end else begin
            countQ <= countD;
            wrapsQ <= wrapsD;
        end
    end

    assign bus.q_o     = countQ;
    assign bus.tc_o    = tcInt;
    assign bus.wraps_o = wrapsQ;

endmodule

// File: tb/tb_mod_m_updown_counter.sv
// Self-checking bench for mod_m_updown_counter. Three instances:
//   dutA  wrapping counter driven directly by the bench
//   dutS  saturating counter receiving the same inputs as dutA
//   dutB  wrapping mod-10 counter whose en is dutA's tc (cascade)
// Expected values come from a behavioural model that uses modular
// arithmetic on plain integers.
module tb_mod_m_updown_counter;

    localparam int N    = 8;
    localparam int W    = 4;
    localparam int WMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mod_m_updown_counter_if #(.N(N), .W(W)) ifA ();
    mod_m_updown_counter_if #(.N(N), .W(W)) ifB ();
    mod_m_updown_counter_if #(.N(N), .W(W)) ifS ();

    mod_m_updown_counter #(.N(N), .W(W), .SAT(0)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (ifA)
    );

    mod_m_updown_counter #(.N(N), .W(W), .SAT(0)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (ifB)
    );

    mod_m_updown_counter #(.N(N), .W(W), .SAT(1)) dutS (
        .clk   (clk),
        .reset (reset),
        .bus   (ifS)
    );

    assign ifB.en_i = ifA.tc_o;

    int testsRun    = 0;
    int testsFailed = 0;

    int mqA = 0, mwA = 0;
    int mqS = 0, mwS = 0;
    int mqB = 0, mwB = 0;

    function automatic int refTc(input int m, input int q, input int en,
                                 input int up, input int clr, input int load);
        if (m < 2) return en;
        if (clr != 0 || load != 0 || q >= m || en == 0) return 0;
        if (up != 0) return (q == m - 1) ? 1 : 0;
        return (q == 0) ? 1 : 0;
    endfunction

    function automatic int refNext(input int sat, input int m, input int q,
                                   input int en, input int up, input int clr,
                                   input int load, input int d);
        if (m < 2) return 0;
        if (clr != 0) return 0;
        if (load != 0) return (d < m) ? d : m - 1;
        if (q >= m) return 0;
        if (en == 0) return q;
        if (up != 0) begin
            if (sat != 0) return (q + 1 < m) ? q + 1 : q;
            return (q + 1) % m;
        end
        if (sat != 0) return (q > 0) ? q - 1 : 0;
        return (q + m - 1) % m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        testsRun++;
        assert (got === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called on a falling edge: drives inputs, checks tc before the rising
    // edge, advances the model on the edge, checks registers afterwards.
    task automatic applyStimulus(input int m, input int en, input int up,
                                 input int clr, input int load, input int d);
        int eTcA, eTcS, eTcB;
        ifA.modM_i = N'(m); ifA.en_i = en[0]; ifA.up_i = up[0];
        ifA.clr_i  = clr[0]; ifA.load_i = load[0]; ifA.d_i = N'(d);
        ifS.modM_i = N'(m); ifS.en_i = en[0]; ifS.up_i = up[0];
        ifS.clr_i  = clr[0]; ifS.load_i = load[0]; ifS.d_i = N'(d);
        #1;
        eTcA = refTc(m, mqA, en, up, clr, load);
        eTcS = refTc(m, mqS, en, up, clr, load);
        eTcB = refTc(10, mqB, eTcA, 1, 0, 0);
        checkOutput("tcA", 32'(ifA.tc_o), eTcA);
        checkOutput("tcS", 32'(ifS.tc_o), eTcS);
        checkOutput("tcB", 32'(ifB.tc_o), eTcB);
        @(posedge clk);
        mqA = refNext(0, m, mqA, en, up, clr, load, d);
        mqS = refNext(1, m, mqS, en, up, clr, load, d);
        mqB = refNext(0, 10, mqB, eTcA, 1, 0, 0, 0);
        if (eTcA != 0 && mwA < WMAX) mwA++;
        if (eTcB != 0 && mwB < WMAX) mwB++;
        @(negedge clk);
        checkOutput("qA", 32'(ifA.q_o), mqA);
        checkOutput("qS", 32'(ifS.q_o), mqS);
        checkOutput("qB", 32'(ifB.q_o), mqB);
        checkOutput("wrapsA", 32'(ifA.wraps_o), mwA);
        checkOutput("wrapsS", 32'(ifS.wraps_o), mwS);
        checkOutput("wrapsB", 32'(ifB.wraps_o), mwB);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic doReset();
        reset = 1'b1;
        #1;
        mqA = 0; mwA = 0; mqS = 0; mwS = 0; mqB = 0; mwB = 0;
        checkOutput("rstQA", 32'(ifA.q_o), 0);
        checkOutput("rstQB", 32'(ifB.q_o), 0);
        checkOutput("rstQS", 32'(ifS.q_o), 0);
        checkOutput("rstWA", 32'(ifA.wraps_o), 0);
        checkOutput("rstWB", 32'(ifB.wraps_o), 0);
        checkOutput("rstWS", 32'(ifS.wraps_o), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int randM;
        reset = 1'b0;
        ifA.modM_i = N'(10); ifA.en_i = 1'b0; ifA.up_i = 1'b1;
        ifA.clr_i = 1'b0; ifA.load_i = 1'b0; ifA.d_i = '0;
        ifS.modM_i = N'(10); ifS.en_i = 1'b0; ifS.up_i = 1'b1;
        ifS.clr_i = 1'b0; ifS.load_i = 1'b0; ifS.d_i = '0;
        ifB.modM_i = N'(10); ifB.up_i = 1'b1;
        ifB.clr_i = 1'b0; ifB.load_i = 1'b0; ifB.d_i = '0;
        #2;
        doReset();

        // Count up through one full wrap of mod 10.
        for (int i = 0; i < 12; i++) applyStimulus(10, 1, 1, 0, 0, 0);
        checkOutput("t1QA", 32'(ifA.q_o), 2);
        checkOutput("t1WrapsA", 32'(ifA.wraps_o), 1);

        // Load 1, then count down across zero.
        applyStimulus(10, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(10, 1, 0, 0, 0, 0);
        checkOutput("t2QA", 32'(ifA.q_o), 8);
        checkOutput("t2WrapsA", 32'(ifA.wraps_o), 2);

        // Out-of-range load clamps; clear beats load.
        applyStimulus(10, 0, 1, 0, 1, 12);
        checkOutput("t3Clamp", 32'(ifA.q_o), 9);
        applyStimulus(10, 0, 1, 1, 1, 5);
        checkOutput("t3ClrLoad", 32'(ifA.q_o), 0);

        // Shrinking the modulus below the count pulls q back to 0 without en.
        applyStimulus(10, 0, 1, 0, 1, 7);
        applyStimulus(5, 0, 1, 0, 0, 0);
        checkOutput("t4Shrink", 32'(ifA.q_o), 0);

        // Saturating instance parks at M-1, then counts down.
        doReset();
        for (int i = 0; i < 15; i++) applyStimulus(10, 1, 1, 0, 0, 0);
        checkOutput("t5Park", 32'(ifS.q_o), 9);
        checkOutput("t5Wraps", 32'(ifS.wraps_o), 0);
        for (int i = 0; i < 3; i++) applyStimulus(10, 1, 0, 0, 0, 0);
        checkOutput("t5Down", 32'(ifS.q_o), 6);

        // Two-digit cascade: B:A counts 00..99 and wraps.
        doReset();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(10, 1, 1, 0, 0, 0);
            checkOutput("cascade", int'(ifB.q_o) * 10 + int'(ifA.q_o), (i + 1) % 100);
        end
        for (int i = 0; i < 57; i++) applyStimulus(10, 1, 1, 0, 0, 0);
        checkOutput("at57", int'(ifB.q_o) * 10 + int'(ifA.q_o), 57);
        doReset();

        // Degenerate moduli.
        applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 3);

        // Randomized mix of all controls, including modulus changes.
        randM = 10;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                randM = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1))
                                                    : int'($urandom_range(2, 20));
            end
            applyStimulus(randM,
                          ($urandom_range(0, 3) != 0) ? 1 : 0,
                          int'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0) ? 1 : 0,
                          ($urandom_range(0, 9) == 0) ? 1 : 0,
                          int'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
